// File: rtl/snn_pkg.sv
// Shared definitions for the spiking-network datapath: decoder FSM encoding
// and the channel-index width helper.
package snn_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_COUNT = 2'd1;
  localparam logic [1:0] ST_SCAN  = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_COUNT = ST_COUNT,
    S_SCAN  = ST_SCAN
  } dec_state_t;

  // A single channel still needs a one-bit index port.
  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/spike_accumulator.sv
// Per-channel spike counter: clears on clr, counts on inc, sticks at all-ones.
module spike_accumulator #(
  parameter int COUNT_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  input  logic                   inc,
  output logic [COUNT_WIDTH-1:0] count
);

  logic [COUNT_WIDTH-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count_reg <= '0;
    end else if (inc && (count_reg != {COUNT_WIDTH{1'b1}})) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/spike_count_decoder.sv
// Output-layer decoder: counts spikes per channel over a fixed window, then
// scans the counts one channel per cycle to find the most active channel.
module spike_count_decoder
  import snn_pkg::*;
#(
  parameter int NUM_INPUTS    = 4,
  parameter int COUNT_WIDTH   = 8,
  parameter int WINDOW_CYCLES = 16,
  parameter int IDX_WIDTH     = idx_width(NUM_INPUTS)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic [NUM_INPUTS-1:0]             spike_in,
  output logic                              busy,
  output logic                              done,
  output logic [NUM_INPUTS*COUNT_WIDTH-1:0] counts,
  output logic [IDX_WIDTH-1:0]              winner
);

  localparam int TIMER_WIDTH = (WINDOW_CYCLES < 1) ? 1 : $clog2(WINDOW_CYCLES + 1);
  localparam logic [TIMER_WIDTH-1:0] LAST_TICK = TIMER_WIDTH'(WINDOW_CYCLES - 1);
  localparam logic [IDX_WIDTH-1:0]   LAST_IDX  = IDX_WIDTH'(NUM_INPUTS - 1);

  dec_state_t state_reg, state_next;
  logic [TIMER_WIDTH-1:0] timer_reg, timer_next;
  logic [IDX_WIDTH-1:0]   scan_reg, scan_next;
  logic [COUNT_WIDTH-1:0] best_reg, best_next;
  logic [IDX_WIDTH-1:0]   winner_reg, winner_next;
  logic                   busy_reg, busy_next;
  logic                   done_reg, done_next;
  logic                   clr_counts;
  logic                   count_en;

  logic [COUNT_WIDTH-1:0] count_arr [NUM_INPUTS];
  logic [COUNT_WIDTH-1:0] count_sel;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_INPUTS; gi++) begin : g_chan
      spike_accumulator #(
        .COUNT_WIDTH(COUNT_WIDTH)
      ) u_acc (
        .clk  (clk),
        .rst  (rst),
        .clr  (clr_counts),
        .inc  (count_en & spike_in[gi]),
        .count(count_arr[gi])
      );
      assign counts[gi*COUNT_WIDTH +: COUNT_WIDTH] = count_arr[gi];
    end
  endgenerate

  assign count_sel = count_arr[scan_reg];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= S_IDLE;
      timer_reg  <= '0;
      scan_reg   <= '0;
      best_reg   <= '0;
      winner_reg <= '0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      timer_reg  <= timer_next;
      scan_reg   <= scan_next;
      best_reg   <= best_next;
      winner_reg <= winner_next;
      busy_reg   <= busy_next;
      done_reg   <= done_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    timer_next  = timer_reg;
    scan_next   = scan_reg;
    best_next   = best_reg;
    winner_next = winner_reg;
    done_next   = 1'b0;
    clr_counts  = 1'b0;
    count_en    = 1'b0;

    case (state_reg)
      S_IDLE: begin
        if (start) begin
          state_next  = S_COUNT;
          timer_next  = '0;
          best_next   = '0;
          winner_next = '0;
          clr_counts  = 1'b1;
        end
      end
      S_COUNT: begin
        count_en = 1'b1;
        if (timer_reg == LAST_TICK) begin
          state_next = S_SCAN;
          scan_next  = '0;
        end else begin
          timer_next = timer_reg + 1'b1;
        end
      end
      S_SCAN: begin
        // Strict compare keeps the lowest index on ties.
        if (count_sel > best_reg) begin
          best_next   = count_sel;
          winner_next = scan_reg;
        end
        if (scan_reg == LAST_IDX) begin
          state_next = S_IDLE;
          done_next  = 1'b1;
        end else begin
          scan_next = scan_reg + 1'b1;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase

    busy_next = (state_next != S_IDLE);
  end

  assign busy   = busy_reg;
  assign done   = done_reg;
  assign winner = winner_reg;

endmodule

// File: tb/tb_spike_count_decoder.sv
// Directed bench for spike_count_decoder: table of spike patterns with
// hand-computed counts/winner, plus sequences for restart, reset and back-to-back.
module tb_spike_count_decoder;

  localparam int N  = 4;
  localparam int CW = 4;
  localparam int W  = 20;
  localparam int IW = 2;
  localparam int DONE_EDGE = W + N + 1;  // start edge to the edge that captures done

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [N-1:0]    spike_in;
  logic            busy;
  logic            done;
  logic [N*CW-1:0] counts;
  logic [IW-1:0]   winner;

  int total  = 0;
  int passed = 0;

  spike_count_decoder #(
    .NUM_INPUTS(N),
    .COUNT_WIDTH(CW),
    .WINDOW_CYCLES(W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .spike_in(spike_in),
    .busy(busy),
    .done(done),
    .counts(counts),
    .winner(winner)
  );

  always #5 clk = ~clk;

  // Channel c spikes at window sample k when period != 0, k % period == 0,
  // and fewer than limit spikes have been issued so far.
  typedef struct {
    string     name;
    int        period [N];
    int        limit  [N];
    int        exp_cnt[N];
    int        exp_win;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic logic [N-1:0] pattern(input int v, input int k);
    logic [N-1:0] s;
    s = '0;
    for (int c = 0; c < N; c++)
      if (vecs[v].period[c] != 0 && (k % vecs[v].period[c]) == 0 &&
          (k / vecs[v].period[c]) < vecs[v].limit[c])
        s[c] = 1'b1;
    return s;
  endfunction

  task automatic set_vec(input int v, input string nm,
                         input int p0, input int p1, input int p2, input int p3,
                         input int l0, input int l1, input int l2, input int l3,
                         input int e0, input int e1, input int e2, input int e3,
                         input int ew);
    vecs[v].name = nm;
    vecs[v].period[0] = p0; vecs[v].period[1] = p1;
    vecs[v].period[2] = p2; vecs[v].period[3] = p3;
    vecs[v].limit[0] = l0;  vecs[v].limit[1] = l1;
    vecs[v].limit[2] = l2;  vecs[v].limit[3] = l3;
    vecs[v].exp_cnt[0] = e0; vecs[v].exp_cnt[1] = e1;
    vecs[v].exp_cnt[2] = e2; vecs[v].exp_cnt[3] = e3;
    vecs[v].exp_win = ew;
  endtask

  // Pulse start and return just after the accepting edge.
  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Called just after the start edge T. Drives the window, re-pulses start at
  // edges ra/rb (0 = none), and returns in the cycle where done is high.
  task automatic run_window(input int v, input int ra, input int rb, output int lat);
    int edges;
    for (int k = 0; k < W; k++) begin
      spike_in = pattern(v, k);
      start = ((k + 1) == ra) || ((k + 1) == rb);
      @(posedge clk); #1;
      check($sformatf("%s busy during window", vecs[v].name), int'(busy), 1);
    end
    start = 1'b0;
    spike_in = '1;  // must be ignored during scan
    edges = W;
    while (!done && edges < 60) begin
      start = ((edges + 1) == ra) || ((edges + 1) == rb);
      @(posedge clk); #1;
      start = 1'b0;
      edges++;
    end
    spike_in = '0;
    lat = edges + 1;
    check($sformatf("%s done latency", vecs[v].name), lat, DONE_EDGE);
    check($sformatf("%s busy at done", vecs[v].name), int'(busy), 0);
    for (int c = 0; c < N; c++)
      check($sformatf("%s count%0d", vecs[v].name, c),
            int'(counts[c*CW +: CW]), vecs[v].exp_cnt[c]);
    check($sformatf("%s winner", vecs[v].name), int'(winner), vecs[v].exp_win);
    $display("run %-12s counts=%h winner=%0d latency=%0d", vecs[v].name, counts, winner, lat);
  endtask

  // Watch a number of idle cycles; no done or busy may appear.
  task automatic expect_quiet(input string name, input int cycles);
    int pulses;
    int busy_seen;
    pulses = 0;
    busy_seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      if (done) pulses++;
      if (busy) busy_seen++;
    end
    check($sformatf("%s extra done pulses", name), pulses, 0);
    check($sformatf("%s busy cycles", name), busy_seen, 0);
  endtask

  initial begin
    int lat;
    //          name        periods       limits            expected counts  win
    set_vec(0, "basic",     2, 1, 0, 4,   31, 31, 31, 31,   10, 15, 0, 5,    1);
    set_vec(1, "tie",       1, 1, 1, 1,    5,  3,  3,  5,    5,  3, 3, 5,    0);
    set_vec(2, "silence",   0, 0, 0, 0,   31, 31, 31, 31,    0,  0, 0, 0,    0);
    set_vec(3, "top_idx",   1, 1, 1, 1,    2,  7,  9, 12,    2,  7, 9, 12,   3);
    set_vec(4, "mid_tie",   1, 1, 1, 1,    4, 11, 11,  6,    4, 11, 11, 6,   1);
    set_vec(5, "all_sat",   1, 1, 1, 1,   31, 31, 31, 31,   15, 15, 15, 15,  0);
    set_vec(6, "ch2_only",  0, 0, 3, 0,   31, 31, 31, 31,    0,  0, 7, 0,    2);

    rst = 1'b1; start = 1'b0; spike_in = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset busy",   int'(busy),   0);
    check("reset done",   int'(done),   0);
    check("reset counts", int'(counts), 0);
    check("reset winner", int'(winner), 0);

    for (int v = 0; v < 7; v++) begin
      pulse_start();
      check($sformatf("%s busy after start", vecs[v].name), int'(busy), 1);
      run_window(v, 0, 0, lat);
      @(posedge clk); #1;
      check($sformatf("%s done one cycle", vecs[v].name), int'(done), 0);
      repeat (2) @(posedge clk);
      #1;
      check($sformatf("%s winner held", vecs[v].name), int'(winner), vecs[v].exp_win);
    end

    // start re-pulsed at T+5 and T+22 must be ignored
    pulse_start();
    run_window(0, 5, 22, lat);
    expect_quiet("restart", 30);

    // reset before edge T+10 discards the run
    pulse_start();
    for (int k = 0; k < 9; k++) begin
      spike_in = pattern(0, k);
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    spike_in = '0;
    check("midreset busy",   int'(busy),   0);
    check("midreset counts", int'(counts), 0);
    check("midreset winner", int'(winner), 0);
    check("midreset done",   int'(done),   0);
    $display("midreset busy=%0d counts=%h winner=%0d", busy, counts, winner);
    expect_quiet("midreset", 30);
    pulse_start();
    run_window(0, 0, 0, lat);
    @(posedge clk); #1;

    // back-to-back: start asserted in the done cycle
    pulse_start();
    run_window(0, 0, 0, lat);
    pulse_start();
    check("b2b busy",   int'(busy),   1);
    check("b2b done",   int'(done),   0);
    check("b2b counts", int'(counts), 0);
    check("b2b winner", int'(winner), 0);
    $display("b2b accepted busy=%0d counts=%h", busy, counts);
    run_window(1, 0, 0, lat);
    expect_quiet("b2b", 5);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
